// File: rtl/mips_sys_pkg.sv
// Shared definitions for the MIPS syscall service stage: service codes,
// output-entry layout and the run/drain/halt state encoding.
package mips_sys_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
  localparam logic [31:0] SYS_EXIT2      = 32'd17;

  typedef enum logic {
    KIND_INT  = 1'b0,
    KIND_CHAR = 1'b1
  } kind_e;

  typedef struct packed {
    kind_e       kind;
    logic [31:0] data;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/syscall_fifo.sv
// First-word-fall-through FIFO of {kind, data} console entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module syscall_fifo
  import mips_sys_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  fifo_entry_t wdata,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  fifo_entry_t mem [DEPTH];

  logic wr_en;
  logic rd_en;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign head  = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mips_syscall_unit.sv
// Syscall service stage behind the single-cycle MIPS core: decodes v0/a0,
// queues console output, stalls on a full queue and halts once drained after exit.
module mips_syscall_unit
  import mips_sys_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        syscall,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        stall,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_kind,
  output logic        halted,
  output logic [31:0] exit_code,
  output logic        bad_code,
  output logic [15:0] svc_count
);

  state_e      state;
  state_e      state_nxt;
  fifo_entry_t push_entry;
  fifo_entry_t head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        is_print;
  logic        is_exit;
  logic        accept;
  logic        push;
  logic        pop;

  assign is_print = (v0 == SYS_PRINT_INT) || (v0 == SYS_PRINT_CHAR);
  assign is_exit  = (v0 == SYS_EXIT) || (v0 == SYS_EXIT2);

  // Stall ignores out_ready, so a full queue never sees a push and pop together.
  assign stall  = syscall && (state == ST_RUN) && is_print && fifo_full;
  assign accept = syscall && (state == ST_RUN) && !stall;
  assign push   = accept && is_print;
  assign pop    = out_valid && out_ready;

  assign push_entry.kind = (v0 == SYS_PRINT_CHAR) ? KIND_CHAR : KIND_INT;
  assign push_entry.data = (v0 == SYS_PRINT_CHAR) ? {24'b0, a0[7:0]} : a0;

  syscall_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head is masked while empty so the payload reads zero out of reset.
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? 32'b0 : head.data;
  assign out_kind  = fifo_empty ? 1'b0 : head.kind;
  assign halted    = (state == ST_HALTED);

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // NOTE: next state is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (accept && is_exit) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (fifo_empty) state_nxt = ST_HALTED;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      exit_code <= '0;
      bad_code  <= 1'b0;
      svc_count <= '0;
    end else if (accept) begin
      if (svc_count != 16'hFFFF) svc_count <= svc_count + 16'd1;
      if (v0 == SYS_EXIT)  exit_code <= '0;
      if (v0 == SYS_EXIT2) exit_code <= a0;
      if (!is_print && !is_exit) bad_code <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_syscall_unit.sv
// Self-checking bench for mips_syscall_unit: a queue-based service model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_mips_syscall_unit;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        syscall;
  logic [31:0] v0;
  logic [31:0] a0;
  logic        stall;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_kind;
  logic        halted;
  logic [31:0] exit_code;
  logic        bad_code;
  logic [15:0] svc_count;

  mips_syscall_unit #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .syscall   (syscall),
    .v0        (v0),
    .a0        (a0),
    .stall     (stall),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_kind  (out_kind),
    .halted    (halted),
    .exit_code (exit_code),
    .bad_code  (bad_code),
    .svc_count (svc_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Service model: queue of pending console entries plus run/exit/halt flags.
  logic [32:0] q[$];
  logic [31:0] got[$];
  bit          m_live = 0;
  bit          m_exited;
  bit          m_halted;
  logic [31:0] m_code;
  bit          m_bad;
  int          m_count;
  int          sz;
  bit          acc;

  function automatic bit model_stall();
    return syscall && !m_exited && (v0 == 32'd1 || v0 == 32'd11) && (q.size() == DEPTH);
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      q.delete();
      m_exited = 0;
      m_halted = 0;
      m_code   = 0;
      m_bad    = 0;
      m_count  = 0;
      m_live   = 1;
    end else if (m_live) begin
      sz  = q.size();
      acc = syscall && !m_exited && !model_stall();
      if (m_exited && sz == 0) m_halted = 1;
      if (sz > 0 && out_ready) void'(q.pop_front());
      if (acc) begin
        if (m_count < 65535) m_count++;
        case (v0)
          32'd1:   q.push_back({1'b0, a0});
          32'd11:  q.push_back({1'b1, 24'b0, a0[7:0]});
          32'd10:  begin m_exited = 1; m_code = 0;  end
          32'd17:  begin m_exited = 1; m_code = a0; end
          default: m_bad = 1;
        endcase
      end
    end
  end

  always @(negedge clock) begin
    if (m_live) begin
      check("stall", stall, model_stall());
      check("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        check("out_data", out_data, q[0][31:0]);
        check("out_kind", out_kind, q[0][32]);
      end
      check("halted", halted, m_halted);
      check("exit_code", exit_code, m_code);
      check("bad_code", bad_code, m_bad);
      check("svc_count", svc_count, m_count);
      if (out_valid && out_ready) got.push_back(out_data);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Present one syscall, holding it through stalls until accepted.
  task automatic do_sys(input logic [31:0] code, input logic [31:0] arg);
    bit st;
    bit done = 0;
    syscall = 1'b1;
    v0      = code;
    a0      = arg;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      st = stall;
      cyc();
      if (!st) done = 1;
    end
    if (!done) check("sys_timeout", 32'd0, 32'd1);
    syscall = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; syscall = 1'b0; v0 = '0; a0 = '0; out_ready = 1'b0;
    #1;
    do_reset();

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_kind", out_kind, 0);
    check("rst_halted", halted, 0);
    check("rst_exit_code", exit_code, 0);
    check("rst_bad_code", bad_code, 0);
    check("rst_svc_count", svc_count, 0);

    // print_int 42, one cycle to head, popped immediately
    out_ready = 1'b1;
    do_sys(32'd1, 32'd42);
    check("pi_valid", out_valid, 1);
    check("pi_data", out_data, 32'd42);
    check("pi_kind", out_kind, 0);
    check("pi_count", svc_count, 1);
    cyc();
    check("pi_popped", out_valid, 0);

    // print_char held stable while not ready
    out_ready = 1'b0;
    do_sys(32'd11, 32'h1234_5641);
    repeat (3) begin
      check("pc_data", out_data, 32'h0000_0041);
      check("pc_kind", out_kind, 1);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    check("pc_popped", out_valid, 0);

    // Fill to DEPTH, fifth print stalls, then drain in order
    out_ready = 1'b0;
    got.delete();
    for (int i = 1; i <= 4; i++) do_sys(32'd1, i);
    syscall = 1'b1; v0 = 32'd1; a0 = 32'd5;
    @(negedge clock);
    check("full_stall", stall, 1);
    cyc();
    out_ready = 1'b1;
    do_sys(32'd1, 32'd5);
    for (int i = 0; i < 20 && out_valid; i++) cyc();
    check("ord_count", got.size(), 5);
    for (int i = 0; i < got.size() && i < 5; i++) check("ord_value", got[i], i + 1);

    // exit2 with three queued entries
    out_ready = 1'b0;
    do_sys(32'd1, 32'd10);
    do_sys(32'd1, 32'd20);
    do_sys(32'd1, 32'd30);
    do_sys(32'd17, 32'd7);
    repeat (2) cyc();
    check("ex_hold_halt", halted, 0);
    out_ready = 1'b1;
    repeat (3) cyc();
    check("ex_drained_halt", halted, 0);
    check("ex_empty", out_valid, 0);
    cyc();
    check("ex_halted", halted, 1);
    check("ex_code", exit_code, 32'd7);
    check("ex_count", svc_count, 32'd11);
    syscall = 1'b1; v0 = 32'd1; a0 = 32'd99;
    @(negedge clock);
    check("halt_nostall", stall, 0);
    cyc();
    syscall = 1'b0;
    check("halt_count", svc_count, 32'd11);
    check("halt_nopush", out_valid, 0);

    // Unknown service code
    do_reset();
    do_sys(32'd99, 32'd0);
    check("bad_flag", bad_code, 1);
    check("bad_count", svc_count, 1);
    check("bad_nopush", out_valid, 0);
    do_sys(32'd1, 32'd3);
    check("bad_sticky", bad_code, 1);
    check("bad_count2", svc_count, 2);

    // exit with empty FIFO: halted two edges after acceptance
    cyc();
    do_sys(32'd10, 32'd123);
    check("e10_not_yet", halted, 0);
    check("e10_code", exit_code, 0);
    cyc();
    check("e10_halted", halted, 1);

    // Reset while draining discards entries
    do_reset();
    out_ready = 1'b0;
    do_sys(32'd1, 32'd100);
    do_sys(32'd1, 32'd200);
    do_sys(32'd10, 32'd0);
    check("dr_pending", out_valid, 1);
    reset = 1'b0;
    cyc();
    check("dr_valid", out_valid, 0);
    check("dr_halted", halted, 0);
    check("dr_count", svc_count, 0);
    check("dr_bad", bad_code, 0);
    check("dr_code", exit_code, 0);
    reset = 1'b1;
    do_sys(32'd1, 32'd5);
    check("dr_run_valid", out_valid, 1);
    check("dr_run_data", out_data, 32'd5);
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_syscall_unit.md
# mips_syscall_unit

Syscall service stage directly downstream of the single-cycle MIPS core. It samples the core's V0/A0 registers on each `syscall` strobe and queues print requests in a small FIFO drained by a console/UART handshake. It latches the exit request and raises `halted` only after all pending output has drained, so benches and the top level stop on `halted` rather than by polling V0 == 10. It stalls the core when the FIFO cannot accept a print.

## Interface
- `DEPTH`, 4: output FIFO entries (power of two, ≥2)
- `clock`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-low (asserted at 0)
- `syscall`  in  1  core is executing a `syscall` this cycle; held high while `stall` is high
- `v0`  in  32  service code (core $v0)
- `a0`  in  32  argument (core $a0)
- `stall`  out  1  combinational; freeze core PC/writes this cycle
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  consumer accepts head
- `out_data`  out  32  head payload
- `out_kind`  out  1  0 = integer, 1 = character (payload in [7:0], [31:8] zero)
- `halted`  out  1  exit taken and FIFO empty; sticky until reset
- `exit_code`  out  32  a0 at exit (0 for code 10)
- `bad_code`  out  1  sticky: unknown service code seen
- `svc_count`  out  16  syscalls serviced, saturating at 16'hFFFF

## Operation
- Service codes: 1 print_int → push {kind 0, a0}; 11 print_char → push {kind 1, {24'b0, a0[7:0]}}; 10 exit → exit_code = 0; 17 exit2 → exit_code = a0; other → set bad_code, no push, counted.
- A syscall is *accepted* on an edge where `syscall`=1, state=RUN and `stall`=0; only accepted syscalls affect FIFO, counters and flags.
- `stall` = `syscall` & state==RUN & (v0==1 | v0==11) & FIFO full. It does not depend on `out_ready`, so a pop and a push to a full FIFO are never combined in one cycle.
- FSM: RUN → (accepted exit) → DRAIN → (FIFO empty) → HALTED. HALTED is left only by reset.
- In DRAIN and HALTED, `syscall` is ignored: no stall, no push, no count. Popping continues in DRAIN.
- Pop occurs on an edge with `out_valid` & `out_ready`. When the FIFO is not full, a push and a pop in the same cycle both take effect and the occupancy is unchanged.
- FIFO read and write pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full = MSBs differ and the other bits are equal.
- Reset values: state RUN, FIFO empty, `out_valid` 0, `out_data` 0, `out_kind` 0, `halted` 0, `exit_code` 0, `bad_code` 0, `svc_count` 0. Reset mid-drain discards queued entries.

## Timing
- Push to `out_valid`: 1 cycle. An entry written at edge N is visible at the head after N when the FIFO was empty. FIFO read data is first-word-fall-through off the storage array.
- `out_data`/`out_kind` are stable while `out_valid`=1 and `out_ready`=0.
- Exit accepted at edge N with the FIFO empty: state DRAIN after N, HALTED and `halted`=1 after N+1.
- Exit with k entries queued and `out_ready` held at 1: `halted`=1 k+1 cycles after the exit edge.
- `svc_count` and `bad_code` update at the accepting edge.
- `stall` has no latency. The core re-presents the same syscall each stalled cycle, and it is accepted on the first non-full cycle.

## Structure
- Package `mips_sys_pkg`: service-code constants (`SYS_PRINT_INT`=1, `SYS_EXIT`=10, `SYS_PRINT_CHAR`=11, `SYS_EXIT2`=17), kind encoding, FSM state encoding (2 bits).
- One sub-module, `syscall_fifo` (parameter DEPTH, 33-bit entries {kind, data}, ports push/pop/full/empty/head). The FSM, counters and decode stay in the top.

## Test plan
- Reset, then print_int with a0=42 and out_ready=1 → one beat out_data=42, out_kind=0, one cycle after the syscall edge; svc_count=1.
- print_char with a0=32'h1234_5641, out_ready=0 → out_data=32'h0000_0041, kind=1, held stable until ready.
- out_ready=0, five print_int calls (a0=1..5) at DEPTH=4 → fifth call sees stall=1. Then raise out_ready → stall drops, output order is 1,2,3,4,5, and no value is lost or duplicated.
- Three print_ints queued with out_ready=0, then exit2 with a0=7 → halted stays 0 until all three are popped, then halted=1 and exit_code=7. A later syscall gives no stall and no count change.
- Syscall with v0=99 → bad_code=1 (sticky), nothing pushed, svc_count increments.
- Assert reset (0) while in DRAIN with 2 entries queued → next cycle out_valid=0, halted=0, state RUN, all counters 0.
